// File: rtl/snes_controller_emulator_pkg.sv
// Shared SNES pad-link constants: button bit positions, frame length and FSM states.
// The host-side pad reader imports the same definitions so both ends agree on bit order.
package snes_controller_emulator_pkg;

    localparam int BUTTON_BITS     = 12;
    localparam int SNES_FRAME_BITS = 16;
    localparam int SR_BITS         = 16;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Wire is active-low; the four reserved trailing bits always read released.
    function automatic logic [SR_BITS-1:0] load_word(input logic [BUTTON_BITS-1:0] buttons);
        return {4'b1111, ~buttons};
    endfunction

endpackage

// File: rtl/snes_controller_emulator_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous host line, followed by a one-flop edge detector
// with registered level/rise/fall outputs.
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   level_reg;
    logic                   rise_reg;
    logic                   fall_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg[0] <= RESET_VAL;
        end else begin
            sync_reg[0] <= async_in;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_reg[gi] <= RESET_VAL;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // Strobes are registered so downstream logic sees level and edge from the same flop stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_reg <= RESET_VAL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            level_reg <= sync_reg[SYNC_STAGES-1];
            rise_reg  <= sync_reg[SYNC_STAGES-1] & ~level_reg;
            fall_reg  <= ~sync_reg[SYNC_STAGES-1] & level_reg;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/snes_controller_emulator.sv
// Pad-side responder for the SNES serial link: latches a 12-bit button word on data_latch
// and shifts it out active-low, one bit per rising snes_clk.
module snes_controller_emulator
    import snes_controller_emulator_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FRAME_BITS  = SNES_FRAME_BITS,
    parameter logic DONE_LEVEL  = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BUTTON_BITS-1:0] button_data,
    input  logic                   data_latch,
    input  logic                   snes_clk,
    output logic                   serial_data,
    output logic                   frame_done,
    output logic                   busy
);

    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
    localparam logic [4:0] CNT_MAX  = 5'(FRAME_BITS);

    logic latch_level, latch_rise, latch_fall;
    logic clk_level, clk_rise, clk_fall;
    logic unused_edges;

    state_t               state_reg, state_next;
    logic [SR_BITS-1:0]   sr_reg, sr_next;
    logic [4:0]           bit_cnt_reg, bit_cnt_next;
    logic                 busy_reg, busy_next;
    logic                 frame_done_reg, frame_done_next;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_latch_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (data_latch),
        .level    (latch_level),
        .rise     (latch_rise),
        .fall     (latch_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clk_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (snes_clk),
        .level    (clk_level),
        .rise     (clk_rise),
        .fall     (clk_fall)
    );

    assign unused_edges = ^{latch_rise, clk_level, clk_fall};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            sr_reg         <= '1;
            bit_cnt_reg    <= '0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sr_reg         <= sr_next;
            bit_cnt_reg    <= bit_cnt_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sr_next         = sr_reg;
        bit_cnt_next    = bit_cnt_reg;
        busy_next       = busy_reg;
        frame_done_next = 1'b0;

        // A held latch overrides everything, aborting any partial frame without frame_done.
        if (latch_level) begin
            state_next   = ST_LOAD;
            sr_next      = load_word(button_data);
            bit_cnt_next = '0;
            busy_next    = 1'b0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    if (latch_fall) begin
                        state_next   = ST_SHIFT;
                        bit_cnt_next = '0;
                        busy_next    = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        sr_next = {1'b1, sr_reg[SR_BITS-1:1]};
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_next      = ST_DONE;
                            bit_cnt_next    = CNT_MAX;
                            busy_next       = 1'b0;
                            frame_done_next = 1'b1;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        case (state_reg)
            ST_LOAD, ST_SHIFT: serial_data = sr_reg[0];
            ST_DONE:           serial_data = DONE_LEVEL;
            default:           serial_data = 1'b1;
        endcase
    end

    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_snes_controller_emulator.sv
// Directed bench for snes_controller_emulator: acts as the console, driving latch and
// snes_clk with slow host timing and checking each serial bit against the button word.
module tb_snes_controller_emulator;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] button_data;
    logic        data_latch;
    logic        snes_clk;
    logic        serial_data;
    logic        frame_done;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int fd_count = 0;
    int fd0;

    snes_controller_emulator #(
        .SYNC_STAGES (2),
        .FRAME_BITS  (16),
        .DONE_LEVEL  (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .button_data (button_data),
        .data_latch  (data_latch),
        .snes_clk    (snes_clk),
        .serial_data (serial_data),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        snes_clk = 1'b0;
        wait_clks(7);
        snes_clk = 1'b1;
        wait_clks(7);
    endtask

    // Latch held ~14 clks; optionally wiggle snes_clk while latched (must be ignored).
    task automatic do_latch(input bit wiggle);
        data_latch = 1'b1;
        if (wiggle) begin
            for (int i = 0; i < 12; i++) begin
                snes_clk = ~snes_clk;
                wait_clks(1);
            end
            snes_clk = 1'b1;
            wait_clks(6);
        end else begin
            wait_clks(14);
        end
        data_latch = 1'b0;
        wait_clks(7);
    endtask

    task automatic read_frame(input logic [11:0] btn, input string tag);
        logic [15:0] word;
        int          fd_start;
        word     = {4'hF, ~btn};
        fd_start = fd_count;
        check($sformatf("%s busy_start", tag), busy, 1);
        check($sformatf("%s bit0", tag), serial_data, word[0]);
        for (int k = 1; k < 16; k++) begin
            pulse();
            check($sformatf("%s bit%0d", tag, k), serial_data, word[k]);
        end
        pulse();
        check($sformatf("%s done_level", tag), serial_data, 0);
        check($sformatf("%s busy_end", tag), busy, 0);
        check($sformatf("%s frame_done_count", tag), fd_count - fd_start, 1);
        $display("frame %s buttons=%03h checked", tag, btn);
    endtask

    initial begin
        reset       = 1'b1;
        data_latch  = 1'b0;
        snes_clk    = 1'b1;
        button_data = 12'h000;
        wait_clks(3);
        check("reset serial_data", serial_data, 1);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);
        reset = 1'b0;
        wait_clks(4);
        check("idle serial_data", serial_data, 1);

        // Only B pressed
        button_data = 12'h001;
        do_latch(1'b0);
        read_frame(12'h001, "t1");

        // Mixed pattern
        button_data = 12'hA5A;
        do_latch(1'b0);
        read_frame(12'hA5A, "t2");

        // Re-latch after 7 pulses aborts the frame
        button_data = 12'h080;
        do_latch(1'b0);
        fd0 = fd_count;
        repeat (7) pulse();
        check("t3 bit7 before relatch", serial_data, 0);
        check("t3 busy before relatch", busy, 1);
        button_data = 12'h000;
        data_latch  = 1'b1;
        wait_clks(5);
        check("t3 new B after relatch", serial_data, 1);
        check("t3 busy after relatch", busy, 0);
        wait_clks(9);
        data_latch = 1'b0;
        wait_clks(7);
        check("t3 no frame_done on abort", fd_count - fd0, 0);
        read_frame(12'h000, "t3b");

        // Extra pulses past the frame do not wrap
        button_data = 12'h3C5;
        do_latch(1'b0);
        fd0 = fd_count;
        read_frame(12'h3C5, "t4");
        for (int p = 17; p <= 20; p++) begin
            pulse();
            check($sformatf("t4 pulse%0d done_level", p), serial_data, 0);
        end
        check("t4 single frame_done", fd_count - fd0, 1);

        // Asynchronous reset mid-frame
        button_data = 12'hFFF;
        do_latch(1'b0);
        repeat (5) pulse();
        check("t5 bit5 before reset", serial_data, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5 serial_data in reset", serial_data, 1);
        check("t5 busy in reset", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_clks(4);
        button_data = 12'h555;
        do_latch(1'b0);
        read_frame(12'h555, "t5b");

        // snes_clk wiggled during latch, buttons changed mid-frame
        button_data = 12'h6A9;
        do_latch(1'b1);
        button_data = 12'h956;
        read_frame(12'h6A9, "t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
